joypad_port_responder: RTL

//  CPU-bus responder for the standard controller ports at $4016/$4017.
//  - Decodes the bus cycles that cpu_2a03 issues (addr/rw/write data).
//  - Latches the OUT[2:0] bits on writes to $4016.
//  - Strobes and serially shifts two 8-button pads back to the CPU on reads.
//  - Sits beside RAM/PPU decode on the system bus; cpu_rdata is muxed onto CPU data_in when rdata_valid=1.

---
 rtl/joypad_port_responder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/joypad_port_responder.sv
// -----------------------------------------------------------------------------
// joypad_port_responder
//
// CPU-bus responder for the two standard controller ports at $4016/$4017.
// Writes to $4016 latch OUT[2:0]; OUT[0] is the pad strobe. While the strobe
// is high both pad shift registers reload continuously from the synchronised
// button inputs. With the strobe low, each read of a port returns that pad's
// next button bit (A first) and advances only that port's shifter. After
// eight bits a port returns FILL_BIT until the next strobe.
//
// Ports
//   clock         system clock, one CPU bus cycle per rising edge
//   nreset        synchronous reset, active-high
//   addr          CPU address bus
//   cpu_wdata     CPU write data
//   rw            1 = read, 0 = write
//   cpu_rdata     read data to CPU (combinational)
//   rdata_valid   high when this block drives the read data (combinational)
//   pad1_buttons  asynchronous button inputs, port 1 (b0 = A ... b7 = Right)
//   pad2_buttons  asynchronous button inputs, port 2
//   out_latch     OUT[2:0] from the last $4016 write
// -----------------------------------------------------------------------------
module joypad_port_responder #(
    parameter int         SYNC_STAGES   = 2,
    parameter logic       FILL_BIT      = 1'b1,
    parameter logic [2:0] OPEN_BUS_BITS = 3'b010
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic [15:0] addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        rw,
    output logic [7:0]  cpu_rdata,
    output logic        rdata_valid,
    input  logic [7:0]  pad1_buttons,
    input  logic [7:0]  pad2_buttons,
    output logic [2:0]  out_latch
);

    localparam logic [3:0] CNT_DONE = 4'd8;

    logic [7:0] sync1 [SYNC_STAGES];
    logic [7:0] sync2 [SYNC_STAGES];
    logic [7:0] pad1_sync;
    logic [7:0] pad2_sync;

    logic [7:0] shreg1;
    logic [7:0] shreg2;
    logic [3:0] cnt1;
    logic [3:0] cnt2;

    logic       hit1;
    logic       hit2;
    logic       strobe;
    logic       sbit1;
    logic       sbit2;
    logic       unused_wdata;

    assign unused_wdata = ^cpu_wdata[7:3];

    assign hit1   = (addr == 16'h4016);
    assign hit2   = (addr == 16'h4017);
    assign strobe = out_latch[0];

    assign pad1_sync = sync1[SYNC_STAGES-1];
    assign pad2_sync = sync2[SYNC_STAGES-1];

    // While strobing, the CPU sees the live (synchronised) A button.
    assign sbit1 = strobe ? pad1_sync[0] : ((cnt1 < CNT_DONE) ? shreg1[0] : FILL_BIT);
    assign sbit2 = strobe ? pad2_sync[0] : ((cnt2 < CNT_DONE) ? shreg2[0] : FILL_BIT);

    always_comb begin
        rdata_valid = rw && (hit1 || hit2);
        cpu_rdata   = 8'h00;
        if (rw && hit1) begin
            cpu_rdata = {OPEN_BUS_BITS, 4'b0000, sbit1};
        end else if (rw && hit2) begin
            cpu_rdata = {OPEN_BUS_BITS, 4'b0000, sbit2};
        end
    end

    always_ff @(posedge clock) begin
        if (nreset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync1[i] <= 8'h00;
                sync2[i] <= 8'h00;
            end
        end else begin
            sync1[0] <= pad1_buttons;
            sync2[0] <= pad2_buttons;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync1[i] <= sync1[i-1];
                sync2[i] <= sync2[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (nreset) begin
            out_latch <= 3'b000;
        end else if (!rw && hit1) begin
            out_latch <= cpu_wdata[2:0];
        end
    end

    // Reload uses the registered strobe, so the write that drops the strobe
    // still performs one final load from the pads.
    always_ff @(posedge clock) begin
        if (nreset) begin
            shreg1 <= 8'h00;
            shreg2 <= 8'h00;
            cnt1   <= CNT_DONE;
            cnt2   <= CNT_DONE;
        end else if (strobe) begin
            shreg1 <= pad1_sync;
            shreg2 <= pad2_sync;
            cnt1   <= 4'd0;
            cnt2   <= 4'd0;
        end else begin
            if (rw && hit1) begin
                shreg1 <= {FILL_BIT, shreg1[7:1]};
                if (cnt1 != CNT_DONE) begin
                    cnt1 <= cnt1 + 4'd1;
                end
            end
            if (rw && hit2) begin
                shreg2 <= {FILL_BIT, shreg2[7:1]};
                if (cnt2 != CNT_DONE) begin
                    cnt2 <= cnt2 + 4'd1;
                end
            end
        end
    end

endmodule
